rr_mux_arbiter: RTL
===================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8; bit width of every data path.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester valid; bit k set means requester k offers a beat on dk.
REQ-005 d0, d1, d2, d3  input  WIDTH each  requester data, which must stay stable while req[k]=1 and gnt[k]=0.
REQ-006 gnt  output  4  one-hot or zero accept; a beat transfers from requester k when req[k]=1 and gnt[k]=1 in the same cycle.
REQ-007 out_valid  output  1  output register holds a beat.
REQ-008 out_data  output  WIDTH  registered selected data.
REQ-009 out_ready  input  1  downstream accepts out_data when out_valid=1 and out_ready=1.
REQ-010 sel  output  2  index of the requester whose beat is in the output register.

Function
REQ-011 Block shall be a 4:1 shared-path round-robin arbiter with a one-entry registered output stage, and it shall have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 Can-load condition: load = (state==EMPTY) or (out_valid and out_ready).
REQ-013 gnt shall be combinational, all zero when load=0 or req=0, and otherwise one-hot at the first k with req[k]=1 searched in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 gnt[k] shall be asserted only when req[k]=1, and at most one gnt bit shall be set in any cycle.
REQ-015 On a clock edge with gnt[k]=1, the block shall set out_data to dk, sel to k, ptr to k, and out_valid to 1; latency is 1 cycle from accept to out_valid.
REQ-016 On a clock edge with out_valid=1, out_ready=1 and gnt=0, the block shall set out_valid to 0 (FULL->EMPTY) and hold out_data and sel.
REQ-017 On a clock edge with out_valid=1, out_ready=0, the block shall hold out_data, sel, ptr and out_valid; gnt=0 (backpressure).
REQ-018 Drain and reload in the same cycle shall be allowed, giving a sustained throughput of one beat per cycle while out_ready=1 and any req is set.
REQ-019 ptr (2-bit, internal) shall change only on a grant, and its wrap from 3 to 0 shall be modulo 4.
REQ-020 A requester may drop req before being granted, and it shall then be skipped with no lost or duplicated beat.
REQ-021 Fairness: with all four req held high and out_ready=1, grants shall be issued in cyclic order, and no requester shall wait more than 3 grants to others.
REQ-022 out_data and sel shall be unchanged whenever out_valid=0 after a drain, and their values are don't-care to downstream.

Reset
REQ-023 While rst=1, asynchronously: out_valid=0, out_data=0, sel=0, ptr=3 (requester 0 first priority), state EMPTY.
REQ-024 While rst=1, gnt shall be forced to 0 regardless of req.
REQ-025 Reset asserted mid-operation shall discard any beat in the output register, and no gnt shall be issued until the first edge after rst deasserts.
REQ-026 After rst deasserts, the first grant shall follow REQ-013 from ptr=3.

Verification
REQ-027 Reset then req=4'b1111, out_ready=1, d0..d3=8'hA0..8'hA3: the bench shall check gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles and out_data A0,A1,A2,A3,A0, each one cycle later.
REQ-028 Single req[2]=1 (d2=8'h5C), out_ready=1: the bench shall check gnt=0100 every cycle, out_valid=1 from the second cycle onward, and sel=2.
REQ-029 Out_valid=1 holding 8'h11 with out_ready=0 for 5 cycles and req=4'b1111: the bench shall check gnt=0 throughout and out_data=8'h11 stable; when out_ready rises, the bench shall check gnt issues the next grant in the same cycle.
REQ-030 Requester 1 granted last, then req=4'b0001: the bench shall check grant goes to 0 (wrap via 2, 3), then with req=4'b1010, gnt=0010.
REQ-031 rst asserted asynchronously between edges while out_valid=1: the bench shall check out_valid=0, out_data=0 and gnt=0 immediately, and after release with req=4'b1000, the first gnt=1000.
REQ-032 req falls to 0 with out_ready=1: the bench shall check out_valid drops one cycle after the last grant and gnt=0 while idle.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : 4:1 round-robin arbiter feeding a one-entry registered output
//               stage with ready/valid handshake on the downstream side.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       sel
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] C_PTR_RESET = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             w_load;
    logic             w_found;
    logic [1:0]       w_idx;
    logic [1:0]       w_gidx;
    logic [3:0]       w_gnt;
    logic [WIDTH-1:0] w_din [4];

    assign w_din[0] = d0;
    assign w_din[1] = d1;
    assign w_din[2] = d2;
    assign w_din[3] = d3;

    // The stage can take a beat when empty or when its current beat drains
    // this cycle; reset suppresses every grant.
    assign w_load = (state_q == ST_EMPTY) || out_ready;

    // Search starts one past the last winner, so the last winner is lowest.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_gidx  = '0;
        if (!rst && w_load) begin
            for (int i = 1; i <= 4; i++) begin
                w_idx = ptr_q + 2'(i);
                if (!w_found && req[w_idx]) begin
                    w_gnt[w_idx] = 1'b1;
                    w_found      = 1'b1;
                    w_gidx       = w_idx;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (w_found) begin
            state_d = ST_FULL;
            ptr_d   = w_gidx;
            sel_d   = w_gidx;
            data_d  = w_din[w_gidx];
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= C_PTR_RESET;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign gnt       = w_gnt;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign sel       = sel_q;

endmodule
`default_nettype wire
